// File: rtl/spi_mem_master.sv
// spi_mem_master: turns parallel write/read requests into 10-bit SPI command
// frames for the slave/RAM wrapper (00 wr-addr, 01 wr-data, 10 rd-addr,
// 11 rd-data), one bit per clk, and returns read data as a one-cycle pulse.
// Optional feature: define SPI_MEM_MASTER_ADDR_CACHE_EN to remember the last
// write/read address and skip the address frame when a request repeats it.
module spi_mem_master #(
  parameter int ADD_SIZE = 8,
  parameter int MISO_DLY = 2,
  parameter int GAP      = 1
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADD_SIZE-1:0] req_addr,
  input  logic [7:0]          req_wdata,
  output logic                rsp_valid,
  output logic [7:0]          rsp_rdata,
  output logic                busy,
  output logic                SS_n,
  output logic                MOSI,
  input  logic                MISO
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_SHIFT, ST_RD_WAIT, ST_CAPTURE, ST_GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [7:0] DLY_LAST = 8'(MISO_DLY - 1);

  state_t     state, state_next;
  logic [7:0] cnt;
  logic       lat_write;
  logic       second;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] sh;
  logic [9:0] frame;
  logic [3:0] bit_idx;
  logic [7:0] req_addr_ext;
  logic       hit;

  assign req_addr_ext = 8'(req_addr);
  assign bit_idx      = 4'd9 - cnt[3:0];

  // Select the frame being sent: address frame first, then data frame.
  always_comb begin
    frame = {2'b00, lat_addr};
    if (second) begin
      frame = lat_write ? {2'b01, lat_wdata} : {2'b11, 8'h00};
    end else if (!lat_write) begin
      frame = {2'b10, lat_addr};
    end
  end

  // State register; reset returns to IDLE immediately, dropping any frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic and the serial/handshake outputs decoded from state.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    SS_n       = 1'b0;
    MOSI       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        SS_n      = 1'b1;
        if (req_valid) state_next = ST_START;
      end
      ST_START: begin
        MOSI       = frame[9];
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        MOSI = frame[bit_idx];
        if (cnt == 8'd9) begin
          if (second && !lat_write)
            state_next = (MISO_DLY == 0) ? ST_CAPTURE : ST_RD_WAIT;
          else
            state_next = ST_GAP;
        end
      end
      ST_RD_WAIT: begin
        if (cnt == DLY_LAST) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cnt == 8'd7) state_next = ST_GAP;
      end
      ST_GAP: begin
        SS_n = 1'b1;
        if (cnt == GAP_LAST) state_next = second ? ST_IDLE : ST_START;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Per-state cycle counter, request latches, MISO shift and read response.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      second    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      sh        <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= (state_next != state) ? 8'd0 : cnt + 8'd1;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr_ext;
            lat_wdata <= req_wdata;
            second    <= hit;
          end
        end
        ST_CAPTURE: begin
          sh <= {sh[6:0], MISO};
          if (cnt == 8'd7) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= {sh[6:0], MISO};
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) second <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_MEM_MASTER_ADDR_CACHE_EN
  logic       wr_vld, rd_vld;
  logic [7:0] wr_addr, rd_addr;

  // A request hits when its address equals the last one sent in its direction.
  always_comb begin
    hit = req_write ? (wr_vld && (wr_addr == req_addr_ext))
                    : (rd_vld && (rd_addr == req_addr_ext));
  end

  // Record the address once its frame has been fully shifted out.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_vld  <= 1'b0;
      rd_vld  <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (state == ST_SHIFT && cnt == 8'd9 && !second) begin
      if (lat_write) begin
        wr_vld  <= 1'b1;
        wr_addr <= lat_addr;
      end else begin
        rd_vld  <= 1'b1;
        rd_addr <= lat_addr;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- Transaction sequencer that drives the SPI slave/RAM wrapper (MOSI, SS_n, MISO) from a simple parallel request/response port.
- Converts each write or read request into the codebase's 10-bit command frames: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- Sits between a local host (CPU or test engine) and the wrapper, on the same clk. No separate SCK; one bit per clk.

Parameters:
- ADD_SIZE, 8, request address width; legal 1..8; zero-extended into the 8-bit frame payload.
- MISO_DLY, 2, clk cycles between the last MOSI bit of a read-data frame and the first MISO sample.
- GAP, 1, minimum SS_n-high cycles between consecutive frames; legal ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high when a request is accepted this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADD_SIZE  RAM address.
- req_wdata  in  8  write data, ignored for reads.
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_rdata  out  8  read data, held until the next read completes.
- busy  out  1  high from acceptance until the last frame's GAP ends.
- SS_n  out  1  slave select to the wrapper, active low.
- MOSI  out  1  serial data to the wrapper.
- MISO  in  1  serial data from the wrapper.

Behaviour:
- Reset values: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, FSM=IDLE, all counters and latches 0. Reset is asserted asynchronously. Deassertion is synchronous to clk.
- Handshake: a request is accepted when req_valid & req_ready. req_ready=1 only in IDLE. On acceptance, latch write/addr/wdata and go to START next cycle. Inputs are don't-care while busy.
- Frame sequence: a write request sends {00,addr} then {01,wdata}. A read request sends {10,addr} then {11,8'h00}.
- FSM states: IDLE → START → SHIFT → (RD_WAIT → CAPTURE, on read-data frames only) → GAP → START (second frame) or IDLE (after last frame).
- START (1 cycle): SS_n=0, MOSI = frame bit 9. This is the slave's command-select cycle.
- SHIFT (10 cycles): MOSI presents frame bits 9..0 MSB first, one per clk. Bit 9 repeats from START. SS_n stays 0.
- RD_WAIT (MISO_DLY cycles): SS_n=0, MOSI=0.
- CAPTURE (8 cycles): sample MISO on each rising edge, MSB first, into a shift register.
- GAP: SS_n=1, MOSI=0, for GAP cycles.
- Read completion: rsp_rdata is updated and rsp_valid pulses for 1 cycle on the first GAP cycle after CAPTURE.
- Latency: frame length is 11 cycles for write/address frames and 11+MISO_DLY+8 for read-data frames, each followed by GAP.
  - Write, GAP=1: 24 cycles from acceptance to busy fall.
  - Read, MISO_DLY=2, GAP=1: 34 cycles.
- busy falls and req_ready rises on the same edge the FSM enters IDLE. A new request is accepted in that IDLE cycle at the earliest, so there is no back-to-back overlap.
- Reset mid-frame: SS_n returns high immediately and the in-flight request is discarded. No rsp_valid pulse.
- req_addr is padded with zeros above ADD_SIZE. Bits of the frame payload above ADD_SIZE are always 0.
- MISO is sampled only in CAPTURE and ignored in every other state.

Optional Feature:
- Macro: SPI_MEM_MASTER_ADDR_CACHE_EN.
- Defined:
  - Keep last_wr_addr/last_rd_addr with valid flags, cleared by reset.
  - If the request address matches the cached address for its direction, skip the address frame.
  - Update the cache when an address frame completes.
  - A cached write takes 12 cycles; a cached read takes 22 cycles.
- Undefined: every request always sends both frames; no cache registers exist.

Test Plan:
- Reset: arst_n low mid-SHIFT → SS_n=1, MOSI=0, busy=0, req_ready=1 asynchronously; no rsp_valid.
- Write addr=8'h3C data=8'hA5 → MOSI frames 00_0011_1100 then 01_1010_0101, SS_n high 1 cycle between; busy high 24 cycles; RAM[0x3C]=0xA5.
- Read after the write, addr=8'h3C → frames 10_0011_1100 and 11_0000_0000; rsp_valid single pulse with rsp_rdata=8'hA5, 34 cycles after acceptance.
- Back-to-back: req_valid held high with write 0x00←0x11 then read 0x00 → second accepted only when req_ready=1 in IDLE; read returns 0x11.
- Boundary addresses: write 0xFF←0x5A and 0x00←0xC3 → both read back correctly; ADD_SIZE=4 variant with addr 4'hF sends payload 8'h0F.
- SPI_MEM_MASTER_ADDR_CACHE_EN defined: two reads of 0x20 → second has no 10-frame, 22 cycles; a write to 0x20 still sends its 00-frame on first use.
